// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, instruction memory request and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
  logic        valid_d_q, valid_d_d;
  logic        valid_f;
  logic        load_valid;
  logic        unused_target_lsbs;

  assign valid_f            = (state_q == RUN);
  assign unused_target_lsbs = ^PCTargetE[1:0];

  always_comb begin
    state_d      = RUN;
    pcf_d        = pcf_q + 32'd4;
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;

    if (state_q == BOOT) begin
      pcf_d = RESET_PC;
    end else if (PCSrcE) begin
      pcf_d = {PCTargetE[31:2], 2'b00};
    end else if (StallF) begin
      // Re-reading the same address keeps imem_rdata stable without a hold buffer.
      pcf_d = pcf_q;
    end

    if (PCSrcE) begin
      instr_d_d    = NOP_INSTR;
      pc_d_d       = 32'd0;
      pc_plus4_d_d = 32'd0;
      valid_d_d    = 1'b0;
    end else if (!StallD) begin
      instr_d_d    = valid_f ? imem_rdata : NOP_INSTR;
      pc_d_d       = pcf_q;
      pc_plus4_d_d = pcf_q + 32'd4;
      valid_d_d    = valid_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pcf_q        <= RESET_PC;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= 32'd0;
      pc_plus4_d_q <= 32'd0;
      valid_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  assign load_valid = !PCSrcE && !StallD && valid_f;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, load_valid};
    flush_count_d = flush_count_q + {31'd0, PCSrcE};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign FlushCount = flush_count_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
  assign FetchCount        = 32'd0;
  assign FlushCount        = 32'd0;
`endif

  assign imem_addr = pcf_d;
  assign imem_en   = ~rst;
  assign PCF       = pcf_q;
  assign InstrD    = instr_d_q;
  assign PCD       = pc_d_q;
  assign PCPlus4D  = pc_plus4_d_q;
  assign ValidD    = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_rdata, imem_addr, PCF, InstrD, PCD, PCPlus4D, FetchCount, FlushCount;
  logic        imem_en, ValidD;

  logic [31:0] w_rdata, w_addr, w_pcf, w_instr, w_pcd, w_pcp4, w_fc, w_flc;
  logic        w_en, w_valid;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= mem(imem_addr);
  always @(posedge clk) if (w_en) w_rdata <= mem(w_addr);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .imem_en(imem_en), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchCount(FetchCount), .FlushCount(FlushCount)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .StallF(1'b0), .StallD(1'b0), .PCSrcE(1'b0),
    .PCTargetE(32'd0), .imem_rdata(w_rdata), .imem_addr(w_addr),
    .imem_en(w_en), .PCF(w_pcf), .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pcp4),
    .ValidD(w_valid), .FetchCount(w_fc), .FlushCount(w_flc)
  );

  always @(negedge clk)
    if (!rst) assert (!(StallD && !StallF)) else $error("illegal hazard input: StallD without StallF");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pcf"}, PCF, 32'd0);
    chk({tag, "_instr"}, InstrD, NOP);
    chk({tag, "_pcd"}, PCD, 32'd0);
    chk({tag, "_pcp4"}, PCPlus4D, 32'd0);
    chk({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
    chk({tag, "_en"}, {31'd0, imem_en}, 32'd0);
    chk({tag, "_fetchcnt"}, FetchCount, 32'd0);
    chk({tag, "_flushcnt"}, FlushCount, 32'd0);
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    #2;
    chk_reset_state("rst0");
    chk("wrap_rst_pcf", w_pcf, 32'hFFFF_FFF8);
    tick; tick;
    rst = 1'b0;
    #1;
    chk("boot_en", {31'd0, imem_en}, 32'd1);
    chk("boot_addr", imem_addr, 32'd0);
    chk("wrap_boot_addr", w_addr, 32'hFFFF_FFF8);

    tick; // edge 1: BOOT
    chk("e1_pcf", PCF, 32'd0);
    chk("e1_valid", {31'd0, ValidD}, 32'd0);
    chk("e1_instr", InstrD, NOP);
    chk("e1_addr", imem_addr, 32'd4);
    chk("wrap_e1_pcf", w_pcf, 32'hFFFF_FFF8);

    tick; // edge 2: first instruction in decode
    chk("e2_pcf", PCF, 32'd4);
    chk("e2_valid", {31'd0, ValidD}, 32'd1);
    chk("e2_instr", InstrD, 32'hA5A5_0000);
    chk("e2_pcd", PCD, 32'd0);
    chk("e2_pcp4", PCPlus4D, 32'd4);
    chk("wrap_e2_pcf", w_pcf, 32'hFFFF_FFFC);

    tick; // edge 3
    chk("e3_pcf", PCF, 32'd8);
    chk("e3_pcd", PCD, 32'd4);
    chk("e3_instr", InstrD, 32'hA5A5_0004);
    chk("wrap_e3_pcf", w_pcf, 32'd0);
    chk("wrap_e3_pcd", w_pcd, 32'hFFFF_FFFC);
    chk("wrap_e3_pcp4", w_pcp4, 32'd0);

    StallF = 1'b1; StallD = 1'b1;
    #1;
    chk("stall_addr", imem_addr, 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pcf", PCF, 32'd8);
      chk("stall_pcd", PCD, 32'd4);
      chk("stall_instr", InstrD, 32'hA5A5_0004);
      chk("stall_addr_hold", imem_addr, 32'd8);
    end
    StallF = 1'b0; StallD = 1'b0;

    tick; // edge 7
    chk("rel_pcd", PCD, 32'd8);
    chk("rel_instr", InstrD, 32'hA5A5_0008);
    chk("rel_pcf", PCF, 32'd12);
    tick; // edge 8
    chk("e8_pcd", PCD, 32'd12);
    chk("e8_pcf", PCF, 32'd16);

    PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
    #1;
    chk("redir_addr", imem_addr, 32'h0000_0100);
    tick; // edge 9
    PCSrcE = 1'b0;
    chk("redir_pcf", PCF, 32'h0000_0100);
    chk("redir_instr", InstrD, NOP);
    chk("redir_valid", {31'd0, ValidD}, 32'd0);
    chk("redir_pcd", PCD, 32'd0);
    chk("redir_flushcnt", FlushCount, PERF ? 32'd1 : 32'd0);
    tick; // edge 10
    chk("tgt_pcd", PCD, 32'h0000_0100);
    chk("tgt_valid", {31'd0, ValidD}, 32'd1);
    chk("tgt_instr", InstrD, 32'hA5A5_0100);
    chk("tgt_pcp4", PCPlus4D, 32'h0000_0104);
    chk("tgt_fetchcnt", FetchCount, PERF ? 32'd5 : 32'd0);

    PCSrcE = 1'b1; PCTargetE = 32'h0000_0203; StallF = 1'b1; StallD = 1'b1;
    #1;
    chk("rs_addr", imem_addr, 32'h0000_0200);
    tick; // edge 11
    PCSrcE = 1'b0; StallF = 1'b0; StallD = 1'b0;
    chk("rs_pcf", PCF, 32'h0000_0200);
    chk("rs_valid", {31'd0, ValidD}, 32'd0);
    chk("rs_instr", InstrD, NOP);
    chk("rs_flushcnt", FlushCount, PERF ? 32'd2 : 32'd0);
    tick; // edge 12
    chk("rs_tgt_pcd", PCD, 32'h0000_0200);
    chk("rs_tgt_instr", InstrD, 32'hA5A5_0200);

    StallF = 1'b1; StallD = 1'b1;
    tick; // edge 13: stalled
    chk("pre_rst_pcf", PCF, 32'h0000_0204);
    #3 rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0;
    tick; // edge 14: BOOT again
    chk("reboot_pcf", PCF, 32'd0);
    chk("reboot_valid", {31'd0, ValidD}, 32'd0);
    chk("reboot_instr", InstrD, NOP);
    tick; // edge 15
    chk("reboot_v2", {31'd0, ValidD}, 32'd1);
    chk("reboot_instr2", InstrD, 32'hA5A5_0000);
    chk("reboot_pcd", PCD, 32'd0);
    chk("reboot_fetchcnt", FetchCount, PERF ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
